uart_tx_frame_serializer: RTL and testbench
===========================================

# uart_tx_frame_serializer

UART transmitter that serializes a parallel byte into a standard asynchronous frame: start bit, 8 data bits LSB first, an optional even/odd parity bit and one stop bit. It runs on the same oversampling clock as the receive path and holds each bit for `prescale` clock cycles, so TX and RX share one clock and one prescale setting. Upstream logic hands it one byte per frame with a single-cycle valid strobe, gated by `Busy`.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame. The bit counter is wide enough for `DATA_WIDTH`-1.
- `CLK` input 1: oversampling clock. All logic is on the rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `P_DATA` input `DATA_WIDTH`: byte to transmit. Sampled only on an accepted `DATA_VALID`.
- `DATA_VALID` input 1: load strobe. Accepted only while `Busy`=0.
- `PAR_EN` input 1: 1 adds a parity bit to the frame.
- `PAR_TYP` input 1: 0 selects even parity, 1 selects odd.
- `prescale` input 6: clock cycles per bit, legal range 1..63. A value of 0 is treated as 1.
- `TX_OUT` output 1: serial line, registered, idles high.
- `Busy` output 1: registered, high for the whole frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept:
  - In IDLE, `DATA_VALID`=1 latches `P_DATA`, `PAR_EN`, `PAR_TYP` and the effective prescale into internal registers, then moves to START.
  - Input changes after acceptance do not affect the frame in flight.
  - `DATA_VALID` in any non-IDLE state is ignored; the byte is dropped and there is no queueing.
- Parity:
  - Computed once at accept from the latched data.
  - Even: the XOR of the data bits. Odd: the inverted XOR.
- Counters:
  - `edge_cnt` (6 bits) counts 0..prescale-1 inside each bit. It clears to 0 on bit end and on entry to START.
  - `bit_cnt` (3 bits for `DATA_WIDTH`=8) counts data bits 0..7. It clears on leaving DATA.
- Transitions (each taken at the bit-end cycle, `edge_cnt`==prescale-1):
  - START goes to DATA.
  - DATA goes to DATA with `bit_cnt`+1 while `bit_cnt`<7. When `bit_cnt`==7 it goes to PARITY if `PAR_EN` is latched, otherwise to STOP.
  - PARITY goes to STOP.
  - STOP goes to IDLE.
- Line value per state:
  - IDLE: 1.
  - START: 0.
  - DATA: `data_reg[bit_cnt]`.
  - PARITY: the parity bit.
  - STOP: 1.
- Reset, asynchronous, including mid-frame:
  - Outputs: `TX_OUT`=1, `Busy`=0.
  - Internal: state=IDLE, all counters and registers at 0.
  - The partial frame is abandoned; there is no stop bit.

## Timing
- Acceptance at rising edge N (IDLE, `DATA_VALID`=1):
  - From cycle N+1: `TX_OUT`=0 and `Busy`=1.
  - The start bit occupies cycles N+1 .. N+prescale.
- Each bit is exactly `prescale` cycles, back to back with no gaps.
  - Frame length: 10×prescale cycles without parity, 11×prescale with parity.
- `Busy` drops to 0 and `TX_OUT` stays 1 in the cycle after the last STOP cycle.
  - The earliest next acceptance is at that cycle's edge.
  - Minimum start-to-start spacing is frame length + 1 cycle.
- With `prescale`=1, every bit is one cycle. Frame length is 10 or 11 cycles.
- A `DATA_VALID` pulse coinciding with the final STOP cycle is ignored, because `Busy` is still 1.

## Test plan
- Basic frame, no parity:
  - Stimulus: `prescale`=8, `PAR_EN`=0, `P_DATA`=0xA5, one-cycle `DATA_VALID`.
  - Response: `TX_OUT` reads 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles. `Busy` is high for 80 cycles, then low.
- Even and odd parity:
  - Stimulus: `prescale`=16, `PAR_EN`=1, `P_DATA`=0x3C.
  - Response with `PAR_TYP`=0: parity bit 0. With `PAR_TYP`=1: parity bit 1.
  - Frame is 176 cycles. Stop bit starts at cycle 161 after acceptance.
- Valid while busy:
  - Stimulus: 0x55 accepted, then `DATA_VALID` with 0xFF at cycle 20 and again on the last STOP cycle.
  - Response: line carries only the 0x55 frame, then idles high.
- Back-to-back frames:
  - Stimulus: `DATA_VALID` held high, data 0x01 then 0x80, `prescale`=4.
  - Response: the second start bit begins exactly 41 cycles after the first.
- Reset mid-frame:
  - Stimulus: `RST` low during data bit 3.
  - Response: `TX_OUT`=1 and `Busy`=0 immediately, asynchronously. After release, a new 0xC3 frame transmits correctly.
- Degenerate and mid-frame config changes:
  - Stimulus: `prescale`=0, `P_DATA`=0x0F, no parity. Separately, toggle `PAR_EN` and `prescale` mid-frame.
  - Response: for `prescale`=0, a 10-cycle frame 0,1,1,1,1,0,0,0,0,1. The mid-frame toggles have no effect on the frame in flight.

Source files
------------

// File: rtl/uart_tx_frame_serializer_if.sv
// Byte-load handshake and serial line between upstream logic and the UART transmitter.
// The master drives the byte and its frame settings; the slave returns the line and busy flag.
interface uart_tx_frame_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic [5:0]            prescale;
    logic                  tx_out;
    logic                  busy;

    modport master (
        output p_data, data_valid, par_en, par_typ, prescale,
        input  tx_out, busy
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ, prescale,
        output tx_out, busy
    );
endinterface

// File: rtl/uart_tx_frame_serializer.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Each bit lasts a prescale number of clock cycles; settings are frozen when a byte is accepted.
module uart_tx_frame_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    uart_tx_frame_serializer_if.slave     bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_data, w_data_next;
    logic                  r_par_en, w_par_en_next;
    logic                  r_par_bit, w_par_bit_next;
    logic [5:0]            r_prescale, w_prescale_next;
    logic [5:0]            r_edge_cnt, w_edge_cnt_next;
    logic [CNT_W-1:0]      r_bit_cnt, w_bit_cnt_next;
    logic                  r_tx_out, w_tx_out_next;
    logic                  r_busy, w_busy_next;

    logic [5:0]            w_prescale_eff;
    logic                  w_bit_end;

    assign w_prescale_eff = (bus.prescale == 6'd0) ? 6'd1 : bus.prescale;
    assign w_bit_end      = (r_edge_cnt == r_prescale - 6'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_prescale <= '0;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx_out   <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_data     <= w_data_next;
            r_par_en   <= w_par_en_next;
            r_par_bit  <= w_par_bit_next;
            r_prescale <= w_prescale_next;
            r_edge_cnt <= w_edge_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_tx_out   <= w_tx_out_next;
            r_busy     <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_data_next     = r_data;
        w_par_en_next   = r_par_en;
        w_par_bit_next  = r_par_bit;
        w_prescale_next = r_prescale;
        w_edge_cnt_next = r_edge_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_tx_out_next   = 1'b1;
        w_busy_next     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.data_valid) begin
                    w_data_next     = bus.p_data;
                    w_par_en_next   = bus.par_en;
                    w_par_bit_next  = (^bus.p_data) ^ bus.par_typ;
                    w_prescale_next = w_prescale_eff;
                    w_edge_cnt_next = '0;
                    w_bit_cnt_next  = '0;
                    w_state_next    = S_START;
                end
            end
            default: begin
                if (!w_bit_end) begin
                    w_edge_cnt_next = r_edge_cnt + 6'd1;
                end else begin
                    w_edge_cnt_next = '0;
                    case (r_state)
                        S_START:  w_state_next = S_DATA;
                        S_DATA: begin
                            if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                                w_bit_cnt_next = '0;
                                w_state_next   = r_par_en ? S_PARITY : S_STOP;
                            end else begin
                                w_bit_cnt_next = r_bit_cnt + 1'b1;
                            end
                        end
                        S_PARITY: w_state_next = S_STOP;
                        default:  w_state_next = S_IDLE;
                    endcase
                end
            end
        endcase

        // Outputs are registered, so the line value is decoded from the upcoming state.
        case (w_state_next)
            S_START:  w_tx_out_next = 1'b0;
            S_DATA:   w_tx_out_next = w_data_next[w_bit_cnt_next];
            S_PARITY: w_tx_out_next = w_par_bit_next;
            default:  w_tx_out_next = 1'b1;
        endcase
        w_busy_next = (w_state_next != S_IDLE);
    end

    assign bus.tx_out = r_tx_out;
    assign bus.busy   = r_busy;
endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Self-checking bench for uart_tx_frame_serializer: table vectors, random frames and corner sequences.
module tb_uart_tx_frame_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_frame_serializer_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame_serializer #(.DATA_WIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic [5:0] pre;
        int         exp_len;
        logic       exp_par;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference frame: bit k/pre of [start, d0..d7, parity?, stop], parity keeps the chosen ones-count sense.
    function automatic logic exp_bit(input logic [7:0] d, input logic pe, input logic pt,
                                     input int pre_eff, input int k);
        int idx;
        idx = k / pre_eff;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == 9 && pe) return (($countones(d) % 2) == 1) ^ pt;
        return 1'b1;
    endfunction

    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] pre, input int pa, input int pb,
                             output int len, output logic par, output int errs);
        int pre_eff;
        int k;
        pre_eff = (pre == 6'd0) ? 1 : int'(pre);
        @(negedge clk);
        bus.p_data     = d;
        bus.par_en     = pe;
        bus.par_typ    = pt;
        bus.prescale   = pre;
        bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
        bus.p_data     = 8'($urandom);
        bus.par_en     = 1'($urandom);
        bus.par_typ    = 1'($urandom);
        bus.prescale   = 6'($urandom);
        k    = 0;
        errs = 0;
        par  = 1'b0;
        while (bus.busy === 1'b1 && k < 2000) begin
            if (bus.tx_out !== exp_bit(d, pe, pt, pre_eff, k)) errs++;
            if (pe && k == 9 * pre_eff + pre_eff / 2) par = bus.tx_out;
            bus.data_valid = (k == pa || k == pb);
            if (bus.data_valid) bus.p_data = 8'hFF;
            k++;
            @(negedge clk);
        end
        bus.data_valid = 1'b0;
        if (bus.tx_out !== 1'b1) errs++;
        len = k;
        $display("[TB] frame data=%02h pe=%0b pt=%0b pre=%0d len=%0d line_errs=%0d",
                 d, pe, pt, pre, len, errs);
    endtask

    initial begin
        int len;
        int errs;
        logic par;
        logic [7:0] rd;
        logic rpe, rpt;
        logic [5:0] rpre;
        int rlen;
        int c, t1, t2;
        logic seen_low;

        vecs[0] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, pre: 6'd8,  exp_len: 80,  exp_par: 1'b0};
        vecs[1] = '{data: 8'h3C, pe: 1'b1, pt: 1'b0, pre: 6'd16, exp_len: 176, exp_par: 1'b0};
        vecs[2] = '{data: 8'h3C, pe: 1'b1, pt: 1'b1, pre: 6'd16, exp_len: 176, exp_par: 1'b1};
        vecs[3] = '{data: 8'h0F, pe: 1'b0, pt: 1'b0, pre: 6'd0,  exp_len: 10,  exp_par: 1'b0};
        vecs[4] = '{data: 8'h55, pe: 1'b1, pt: 1'b0, pre: 6'd3,  exp_len: 33,  exp_par: 1'b0};
        vecs[5] = '{data: 8'h01, pe: 1'b1, pt: 1'b0, pre: 6'd1,  exp_len: 11,  exp_par: 1'b1};
        vecs[6] = '{data: 8'hFF, pe: 1'b1, pt: 1'b1, pre: 6'd63, exp_len: 693, exp_par: 1'b1};

        bus.p_data     = '0;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        bus.par_typ    = 1'b0;
        bus.prescale   = 6'd1;

        repeat (3) @(negedge clk);
        check("reset_tx", int'(bus.tx_out), 1);
        check("reset_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_tx", int'(bus.tx_out), 1);
        check("idle_busy", int'(bus.busy), 0);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].pre, -1, -1, len, par, errs);
            check($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
            check($sformatf("vec%0d_line", i), errs, 0);
            if (vecs[i].pe) check($sformatf("vec%0d_par", i), int'(par), int'(vecs[i].exp_par));
        end

        // Valid pulses at cycle 20 and on the last stop cycle must both be dropped.
        run_frame(8'h55, 1'b0, 1'b0, 6'd4, 19, 39, len, par, errs);
        check("busy_drop_len", len, 40);
        check("busy_drop_line", errs, 0);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) errs++;
            @(negedge clk);
        end
        check("busy_drop_idle", errs, 0);

        // Back-to-back with valid held high.
        @(negedge clk);
        bus.p_data     = 8'h01;
        bus.par_en     = 1'b0;
        bus.par_typ    = 1'b0;
        bus.prescale   = 6'd4;
        bus.data_valid = 1'b1;
        c = 0; t1 = -1; t2 = -1; seen_low = 1'b0;
        while (t2 < 0 && c < 300) begin
            @(negedge clk);
            c++;
            if (t1 < 0 && bus.busy === 1'b1) t1 = c;
            else if (t1 >= 0 && bus.busy === 1'b0) begin
                seen_low    = 1'b1;
                bus.p_data  = 8'h80;
            end else if (seen_low && bus.busy === 1'b1) t2 = c;
        end
        bus.data_valid = 1'b0;
        check("b2b_spacing", t2 - t1, 41);
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.tx_out !== exp_bit(8'h80, 1'b0, 1'b0, 4, k)) errs++;
            @(negedge clk);
        end
        if (bus.busy !== 1'b0 || bus.tx_out !== 1'b1) errs++;
        check("b2b_second_frame", errs, 0);
        $display("[TB] back-to-back t1=%0d t2=%0d", t1, t2);

        // Asynchronous reset during data bit 3.
        @(negedge clk);
        bus.p_data     = 8'hA5;
        bus.par_en     = 1'b0;
        bus.prescale   = 6'd4;
        bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
        repeat (17) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", int'(bus.tx_out), 1);
        check("async_rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(8'hC3, 1'b1, 1'b0, 6'd5, -1, -1, len, par, errs);
        check("post_rst_len", len, 55);
        check("post_rst_line", errs, 0);
        check("post_rst_par", int'(par), 0);

        // Random frames against the reference.
        for (int i = 0; i < 24; i++) begin
            rd   = 8'($urandom);
            rpe  = 1'($urandom);
            rpt  = 1'($urandom);
            rpre = 6'($urandom_range(0, 10));
            rlen = (rpe ? 11 : 10) * ((rpre == 6'd0) ? 1 : int'(rpre));
            run_frame(rd, rpe, rpt, rpre, -1, -1, len, par, errs);
            check($sformatf("rnd%0d_len", i), len, rlen);
            check($sformatf("rnd%0d_line", i), errs, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
